// File: rtl/instr_encoder.sv
// Host-side instruction encoder: turns op requests (single ops and LOADI16 macros) into
// 16-bit instruction words for the instruction memory write port, using valid/ready on both sides.
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_loadi,
    input  logic [3:0]       req_opcode,
    input  logic [3:0]       req_rd,
    input  logic [3:0]       req_rs1,
    input  logic [3:0]       req_rs2,
    input  logic [15:0]      req_imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [15:0]      instr,
    output logic             instr_last,
    output logic             err_illegal,
    output logic [CNT_W-1:0] words_issued,
    output logic [CNT_W-1:0] reqs_done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EMIT    = 2'd1;
    localparam logic [1:0] EMIT_LO = 2'd2;
    localparam logic [1:0] EMIT_HI = 2'd3;

    localparam logic [3:0] OP_LIL = 4'b0101;
    localparam logic [3:0] OP_LIH = 4'b0110;

    logic [1:0]       state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic [15:0]      hiWord_q, hiWord_d;
    logic             errIllegal_q, errIllegal_d;
    logic [CNT_W-1:0] wordsIssued_q, wordsIssued_d;
    logic [CNT_W-1:0] reqsDone_q, reqsDone_d;

    logic handshake;
    logic accept;
    logic illegalOp;

    assign instr_valid  = (state_q != IDLE);
    assign instr_last   = (state_q == EMIT) || (state_q == EMIT_HI);
    assign instr        = instr_q;
    assign err_illegal  = errIllegal_q;
    assign words_issued = wordsIssued_q;
    assign reqs_done    = reqsDone_q;

    // A new request may enter in the same cycle the final word of the previous one hands off.
    assign handshake = instr_valid & instr_ready;
    assign req_ready = (state_q == IDLE) | (instr_valid & instr_last & instr_ready);
    assign accept    = req_valid & req_ready;

    always_comb begin
        illegalOp = 1'b0;
        if (!req_loadi) begin
            case (req_opcode)
                4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1100: illegalOp = 1'b1;
                default:                                     illegalOp = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        hiWord_d      = hiWord_q;
        errIllegal_d  = 1'b0;
        wordsIssued_d = wordsIssued_q;
        reqsDone_d    = reqsDone_q;

        if (handshake) begin
            wordsIssued_d = wordsIssued_q + CNT_W'(1);
            if (instr_last) begin
                reqsDone_d = reqsDone_q + CNT_W'(1);
            end
            if (state_q == EMIT_LO) begin
                state_d = EMIT_HI;
                instr_d = hiWord_q;
            end else begin
                state_d = IDLE;
            end
        end

        // LIL/LIH single ops share the R-type bit layout, since imm8 = {rs1, rs2}.
        if (accept) begin
            if (req_loadi) begin
                state_d  = EMIT_LO;
                instr_d  = {OP_LIL, req_rd, req_imm[7:0]};
                hiWord_d = {OP_LIH, req_rd, req_imm[15:8]};
            end else if (illegalOp) begin
                state_d      = IDLE;
                errIllegal_d = 1'b1;
            end else begin
                state_d = EMIT;
                instr_d = {req_opcode, req_rd, req_rs1, req_rs2};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            hiWord_q      <= '0;
            errIllegal_q  <= 1'b0;
            wordsIssued_q <= '0;
            reqsDone_q    <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            hiWord_q      <= hiWord_d;
            errIllegal_q  <= errIllegal_d;
            wordsIssued_q <= wordsIssued_d;
            reqsDone_q    <= reqsDone_d;
        end
    end

endmodule
